// File: rtl/ysyx_22050133_pkg.sv
//------------------------------------------------------------------------------
// Module  : ysyx_22050133_pkg
// Purpose : Shared types and constants for the ysyx_22050133 AXI front end:
//           arbiter state encoding, grant identifiers, AXI burst/size codes.
// Ports   : none (package)
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package ysyx_22050133_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_IF_RD      = 3'd1,
    ST_LS_RD      = 3'd2,
    ST_LS_WR      = 3'd3,
    ST_LS_WR_WAIT = 3'd4
  } arb_state_e;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_LS = 1'b1
  } grant_e;

  localparam logic [1:0] BURST_INCR = 2'b01;

  localparam logic [2:0] AXI_SIZE_1B = 3'b000;
  localparam logic [2:0] AXI_SIZE_2B = 3'b001;
  localparam logic [2:0] AXI_SIZE_4B = 3'b010;
  localparam logic [2:0] AXI_SIZE_8B = 3'b011;

endpackage

`default_nettype wire

// File: rtl/ysyx_22050133_rr_pick2.sv
//------------------------------------------------------------------------------
// Module  : ysyx_22050133_rr_pick2
// Purpose : Two-way round-robin picker. A lone requester wins; on a tie the
//           client that was not granted last wins.
// Ports   : if_req_i      - IFU request
//           ls_req_i      - LSU request
//           last_grant_i  - client granted most recently
//           valid_o       - at least one request present
//           grant_o       - selected client (meaningful when valid_o = 1)
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module ysyx_22050133_rr_pick2
  import ysyx_22050133_pkg::*;
(
  input  logic   if_req_i,
  input  logic   ls_req_i,
  input  grant_e last_grant_i,
  output logic   valid_o,
  output grant_e grant_o
);

  always_comb begin
    valid_o = if_req_i | ls_req_i;
    grant_o = GNT_IF;
    if (if_req_i && ls_req_i) begin
      grant_o = (last_grant_i == GNT_IF) ? GNT_LS : GNT_IF;
    end else if (ls_req_i) begin
      grant_o = GNT_LS;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ysyx_22050133_axi_arbiter.sv
//------------------------------------------------------------------------------
// Module  : ysyx_22050133_axi_arbiter
// Purpose : Arbitrates the IFU (read-only) and LSU (read/write) onto a single
//           AXI-like master port, one transaction at a time, round-robin.
// Ports   : clk, rst               - clock, async active-high reset
//           if_addr_* / if_r_*     - IFU address request and read data
//           ls_addr_* / ls_w_* /
//           ls_r_* / ls_w_done_o   - LSU address, write data, read data,
//                                    write-complete pulse
//           rw_addr_* / rw_*       - master address channel
//           w_data_* / r_data_*    - master write and read data channels
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module ysyx_22050133_axi_arbiter
  import ysyx_22050133_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  // IFU
  input  logic              if_addr_valid_i,
  output logic              if_addr_ready_o,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic [7:0]        if_len_i,
  input  logic [2:0]        if_size_i,
  output logic              if_r_valid_o,
  input  logic              if_r_ready_i,
  output logic [DATA_W-1:0] if_r_data_o,
  // LSU
  input  logic              ls_addr_valid_i,
  output logic              ls_addr_ready_o,
  input  logic [ADDR_W-1:0] ls_addr_i,
  input  logic              ls_we_i,
  input  logic [7:0]        ls_len_i,
  input  logic [2:0]        ls_size_i,
  input  logic              ls_w_valid_i,
  output logic              ls_w_ready_o,
  input  logic [DATA_W-1:0] ls_w_data_i,
  output logic              ls_r_valid_o,
  input  logic              ls_r_ready_i,
  output logic [DATA_W-1:0] ls_r_data_o,
  output logic              ls_w_done_o,
  // Master
  output logic              rw_addr_valid_o,
  input  logic              rw_addr_ready_i,
  output logic [ADDR_W-1:0] rw_addr_o,
  output logic              rw_we_o,
  output logic [7:0]        rw_len_o,
  output logic [2:0]        rw_size_o,
  output logic [1:0]        rw_burst_o,
  output logic              w_data_valid_o,
  input  logic              w_data_ready_i,
  output logic [DATA_W-1:0] w_data_o,
  input  logic              r_data_valid_i,
  output logic              r_data_ready_o,
  input  logic [DATA_W-1:0] r_data_i
);

  arb_state_e state_q, state_d;
  grant_e     last_grant_q, last_grant_d;
  logic       addr_sent_q, addr_sent_d;
  logic [7:0] cnt_q, cnt_d;
  logic       done_q, done_d;

  logic       pick_valid;
  grant_e     pick_grant;

  ysyx_22050133_rr_pick2 u_rr_pick2 (
    .if_req_i     (if_addr_valid_i),
    .ls_req_i     (ls_addr_valid_i),
    .last_grant_i (last_grant_q),
    .valid_o      (pick_valid),
    .grant_o      (pick_grant)
  );

  // Address-phase owners; LS_WR_WAIT deliberately owns no address channel.
  logic sel_if, sel_ls, in_rd, addr_hs, rd_beat, wr_beat, beat, last_beat;

  always_comb begin
    sel_if          = (state_q == ST_IF_RD);
    sel_ls          = (state_q == ST_LS_RD) || (state_q == ST_LS_WR);
    in_rd           = (state_q == ST_IF_RD) || (state_q == ST_LS_RD);

    rw_addr_valid_o = ((sel_if & if_addr_valid_i) | (sel_ls & ls_addr_valid_i)) & ~addr_sent_q;
    if_addr_ready_o = sel_if & rw_addr_ready_i & ~addr_sent_q;
    ls_addr_ready_o = sel_ls & rw_addr_ready_i & ~addr_sent_q;
    rw_addr_o       = sel_if ? if_addr_i : (sel_ls ? ls_addr_i : '0);
    rw_len_o        = sel_if ? if_len_i  : (sel_ls ? ls_len_i  : 8'd0);
    rw_size_o       = sel_if ? if_size_i : (sel_ls ? ls_size_i : 3'd0);
    rw_we_o         = sel_ls & ls_we_i;
    rw_burst_o      = BURST_INCR;

    if_r_valid_o    = (state_q == ST_IF_RD) & r_data_valid_i;
    ls_r_valid_o    = (state_q == ST_LS_RD) & r_data_valid_i;
    if_r_data_o     = r_data_i;
    ls_r_data_o     = r_data_i;
    r_data_ready_o  = ((state_q == ST_IF_RD) & if_r_ready_i) |
                      ((state_q == ST_LS_RD) & ls_r_ready_i);

    // Write data may only flow once the address has been accepted.
    w_data_valid_o  = (state_q == ST_LS_WR) & ls_w_valid_i & addr_sent_q;
    ls_w_ready_o    = (state_q == ST_LS_WR) & w_data_ready_i & addr_sent_q;
    w_data_o        = ls_w_data_i;

    ls_w_done_o     = done_q;

    addr_hs         = rw_addr_valid_o & rw_addr_ready_i;
    rd_beat         = in_rd & r_data_valid_i & r_data_ready_o & addr_sent_q;
    wr_beat         = w_data_valid_o & w_data_ready_i;
    beat            = rd_beat | wr_beat;
    last_beat       = (cnt_q == 8'd0);
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    addr_sent_d  = addr_sent_q;
    cnt_d        = cnt_q;
    done_d       = 1'b0;

    if (addr_hs) begin
      addr_sent_d = 1'b1;
      cnt_d       = sel_if ? if_len_i : ls_len_i;
    end else if (beat && !last_beat) begin
      cnt_d = cnt_q - 8'd1;
    end

    case (state_q)
      ST_IDLE: begin
        addr_sent_d = 1'b0;
        if (pick_valid) begin
          last_grant_d = pick_grant;
          if (pick_grant == GNT_IF)  state_d = ST_IF_RD;
          else if (ls_we_i)          state_d = ST_LS_WR;
          else                       state_d = ST_LS_RD;
        end
      end
      ST_IF_RD, ST_LS_RD: begin
        if (beat && last_beat) begin
          state_d     = ST_IDLE;
          addr_sent_d = 1'b0;
        end
      end
      ST_LS_WR: begin
        if (beat && last_beat) state_d = ST_LS_WR_WAIT;
      end
      ST_LS_WR_WAIT: begin
        // The master reuses addr_ready to signal write-response completion.
        if (rw_addr_ready_i) begin
          state_d     = ST_IDLE;
          addr_sent_d = 1'b0;
          done_d      = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        addr_sent_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GNT_LS;
      addr_sent_q  <= 1'b0;
      cnt_q        <= 8'd0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_sent_q  <= addr_sent_d;
      cnt_q        <= cnt_d;
      done_q       <= done_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22050133_axi_arbiter.sv
//------------------------------------------------------------------------------
// Module  : tb_ysyx_22050133_axi_arbiter
// Purpose : Directed self-checking bench for ysyx_22050133_axi_arbiter.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ysyx_22050133_axi_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_addr_valid_i, if_addr_ready_o;
  logic [31:0] if_addr_i;
  logic [7:0]  if_len_i;
  logic [2:0]  if_size_i;
  logic        if_r_valid_o, if_r_ready_i;
  logic [63:0] if_r_data_o;
  logic        ls_addr_valid_i, ls_addr_ready_o;
  logic [31:0] ls_addr_i;
  logic        ls_we_i;
  logic [7:0]  ls_len_i;
  logic [2:0]  ls_size_i;
  logic        ls_w_valid_i, ls_w_ready_o;
  logic [63:0] ls_w_data_i;
  logic        ls_r_valid_o, ls_r_ready_i;
  logic [63:0] ls_r_data_o;
  logic        ls_w_done_o;
  logic        rw_addr_valid_o, rw_addr_ready_i;
  logic [31:0] rw_addr_o;
  logic        rw_we_o;
  logic [7:0]  rw_len_o;
  logic [2:0]  rw_size_o;
  logic [1:0]  rw_burst_o;
  logic        w_data_valid_o, w_data_ready_i;
  logic [63:0] w_data_o;
  logic        r_data_valid_i, r_data_ready_o;
  logic [63:0] r_data_i;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ysyx_22050133_axi_arbiter dut (
    .clk(clk), .rst(rst),
    .if_addr_valid_i(if_addr_valid_i), .if_addr_ready_o(if_addr_ready_o),
    .if_addr_i(if_addr_i), .if_len_i(if_len_i), .if_size_i(if_size_i),
    .if_r_valid_o(if_r_valid_o), .if_r_ready_i(if_r_ready_i), .if_r_data_o(if_r_data_o),
    .ls_addr_valid_i(ls_addr_valid_i), .ls_addr_ready_o(ls_addr_ready_o),
    .ls_addr_i(ls_addr_i), .ls_we_i(ls_we_i), .ls_len_i(ls_len_i), .ls_size_i(ls_size_i),
    .ls_w_valid_i(ls_w_valid_i), .ls_w_ready_o(ls_w_ready_o), .ls_w_data_i(ls_w_data_i),
    .ls_r_valid_o(ls_r_valid_o), .ls_r_ready_i(ls_r_ready_i), .ls_r_data_o(ls_r_data_o),
    .ls_w_done_o(ls_w_done_o),
    .rw_addr_valid_o(rw_addr_valid_o), .rw_addr_ready_i(rw_addr_ready_i),
    .rw_addr_o(rw_addr_o), .rw_we_o(rw_we_o), .rw_len_o(rw_len_o),
    .rw_size_o(rw_size_o), .rw_burst_o(rw_burst_o),
    .w_data_valid_o(w_data_valid_o), .w_data_ready_i(w_data_ready_i), .w_data_o(w_data_o),
    .r_data_valid_i(r_data_valid_i), .r_data_ready_o(r_data_ready_o), .r_data_i(r_data_i)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after a rising edge; checks run 1 unit later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  // Every client/master handshake output that must be low when nothing is granted.
  task automatic chk_quiet(input string tag);
    chk({tag, ".rw_addr_valid"}, {63'd0, rw_addr_valid_o}, 64'd0);
    chk({tag, ".if_addr_ready"}, {63'd0, if_addr_ready_o}, 64'd0);
    chk({tag, ".ls_addr_ready"}, {63'd0, ls_addr_ready_o}, 64'd0);
    chk({tag, ".if_r_valid"},    {63'd0, if_r_valid_o},    64'd0);
    chk({tag, ".ls_r_valid"},    {63'd0, ls_r_valid_o},    64'd0);
    chk({tag, ".ls_w_ready"},    {63'd0, ls_w_ready_o},    64'd0);
    chk({tag, ".w_data_valid"},  {63'd0, w_data_valid_o},  64'd0);
    chk({tag, ".r_data_ready"},  {63'd0, r_data_ready_o},  64'd0);
  endtask

  initial begin
    int beats;
    rst = 1'b1;
    if_addr_valid_i = 0; if_addr_i = 0; if_len_i = 0; if_size_i = 3'b011; if_r_ready_i = 0;
    ls_addr_valid_i = 0; ls_addr_i = 0; ls_we_i = 0; ls_len_i = 0; ls_size_i = 3'b011;
    ls_w_valid_i = 0; ls_w_data_i = 0; ls_r_ready_i = 0;
    rw_addr_ready_i = 1; w_data_ready_i = 1; r_data_valid_i = 0; r_data_i = 0;

    // ---------------- reset state ----------------
    settle();
    chk_quiet("reset");
    chk("reset.w_done", {63'd0, ls_w_done_o}, 64'd0);
    tick(); tick();
    rst = 1'b0;

    // ---------------- IF single read ----------------
    if_addr_valid_i = 1; if_addr_i = 32'h8000_0000; if_len_i = 8'd0;
    settle();
    chk("if1.idle_no_valid", {63'd0, rw_addr_valid_o}, 64'd0);
    tick();
    settle();
    chk("if1.addr_valid", {63'd0, rw_addr_valid_o}, 64'd1);
    chk("if1.addr",       {32'd0, rw_addr_o}, 64'h8000_0000);
    chk("if1.we",         {63'd0, rw_we_o}, 64'd0);
    chk("if1.burst",      {62'd0, rw_burst_o}, 64'd1);
    chk("if1.if_ready",   {63'd0, if_addr_ready_o}, 64'd1);
    chk("if1.ls_ready",   {63'd0, ls_addr_ready_o}, 64'd0);
    tick();
    if_addr_valid_i = 0;
    r_data_valid_i = 1; r_data_i = 64'h1122334455667788; if_r_ready_i = 1;
    settle();
    chk("if1.addr_done",  {63'd0, rw_addr_valid_o}, 64'd0);
    chk("if1.r_valid",    {63'd0, if_r_valid_o}, 64'd1);
    chk("if1.r_data",     if_r_data_o, 64'h1122334455667788);
    chk("if1.r_ready",    {63'd0, r_data_ready_o}, 64'd1);
    chk("if1.ls_r_valid", {63'd0, ls_r_valid_o}, 64'd0);
    tick();
    settle();
    chk_quiet("if1.back_idle");
    r_data_valid_i = 0; if_r_ready_i = 0;

    // ---------------- tie arbitration after reset ----------------
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    if_addr_valid_i = 1; if_addr_i = 32'h8000_0040; if_len_i = 0;
    ls_addr_valid_i = 1; ls_addr_i = 32'h8000_0100; ls_we_i = 0; ls_len_i = 0;
    tick();
    settle();
    chk("tie1.addr_if",   {32'd0, rw_addr_o}, 64'h8000_0040);
    chk("tie1.if_ready",  {63'd0, if_addr_ready_o}, 64'd1);
    chk("tie1.ls_ready",  {63'd0, ls_addr_ready_o}, 64'd0);
    tick();
    if_addr_valid_i = 0; r_data_valid_i = 1; r_data_i = 64'hA5A5; if_r_ready_i = 1;
    settle();
    chk("tie1.if_r_valid", {63'd0, if_r_valid_o}, 64'd1);
    chk("tie1.ls_r_valid", {63'd0, ls_r_valid_o}, 64'd0);
    tick();
    // IF re-requests while LS is still pending: tie, IF was last, so LS wins.
    r_data_valid_i = 0; if_r_ready_i = 0;
    if_addr_valid_i = 1; if_addr_i = 32'h8000_0080;
    settle();
    chk("tie2.idle", {63'd0, rw_addr_valid_o}, 64'd0);
    tick();
    settle();
    chk("tie2.addr_ls",  {32'd0, rw_addr_o}, 64'h8000_0100);
    chk("tie2.ls_ready", {63'd0, ls_addr_ready_o}, 64'd1);
    chk("tie2.if_ready", {63'd0, if_addr_ready_o}, 64'd0);
    tick();
    ls_addr_valid_i = 0; r_data_valid_i = 1; r_data_i = 64'h5A5A; ls_r_ready_i = 1;
    settle();
    chk("tie2.ls_r_valid", {63'd0, ls_r_valid_o}, 64'd1);
    chk("tie2.ls_r_data",  ls_r_data_o, 64'h5A5A);
    chk("tie2.if_r_valid", {63'd0, if_r_valid_o}, 64'd0);
    tick();
    r_data_valid_i = 0; ls_r_ready_i = 0;
    tick();
    settle();
    chk("tie3.addr_if", {32'd0, rw_addr_o}, 64'h8000_0080);
    chk("tie3.valid",   {63'd0, rw_addr_valid_o}, 64'd1);
    tick();
    if_addr_valid_i = 0; r_data_valid_i = 1; if_r_ready_i = 1;
    tick();
    r_data_valid_i = 0; if_r_ready_i = 0;

    // ---------------- LS write, len 1 ----------------
    ls_addr_valid_i = 1; ls_addr_i = 32'h8000_0010; ls_we_i = 1; ls_len_i = 8'd1;
    tick();
    ls_w_valid_i = 1; ls_w_data_i = 64'hAAAA_0000_0000_000A;
    settle();
    chk("wr.we",          {63'd0, rw_we_o}, 64'd1);
    chk("wr.len",         {56'd0, rw_len_o}, 64'd1);
    chk("wr.addr",        {32'd0, rw_addr_o}, 64'h8000_0010);
    chk("wr.w_valid_pre", {63'd0, w_data_valid_o}, 64'd0);
    chk("wr.w_ready_pre", {63'd0, ls_w_ready_o}, 64'd0);
    tick();
    ls_addr_valid_i = 0;
    settle();
    chk("wr.beat0_valid", {63'd0, w_data_valid_o}, 64'd1);
    chk("wr.beat0_data",  w_data_o, 64'hAAAA_0000_0000_000A);
    chk("wr.beat0_ready", {63'd0, ls_w_ready_o}, 64'd1);
    tick();
    ls_w_data_i = 64'hBBBB_0000_0000_000B;
    settle();
    chk("wr.beat1_valid", {63'd0, w_data_valid_o}, 64'd1);
    chk("wr.beat1_data",  w_data_o, 64'hBBBB_0000_0000_000B);
    tick();
    ls_w_valid_i = 0; rw_addr_ready_i = 0;
    settle();
    chk("wr.wait_w_ready", {63'd0, ls_w_ready_o}, 64'd0);
    chk("wr.wait_done0",   {63'd0, ls_w_done_o}, 64'd0);
    chk("wr.wait_avalid",  {63'd0, rw_addr_valid_o}, 64'd0);
    tick();
    settle();
    chk("wr.wait_done1", {63'd0, ls_w_done_o}, 64'd0);
    rw_addr_ready_i = 1;
    tick();
    settle();
    chk("wr.done_pulse", {63'd0, ls_w_done_o}, 64'd1);
    tick();
    settle();
    chk("wr.done_clear", {63'd0, ls_w_done_o}, 64'd0);
    ls_we_i = 0;

    // ---------------- IF burst len 3 with r_ready toggling ----------------
    if_addr_valid_i = 1; if_addr_i = 32'h8000_0200; if_len_i = 8'd3;
    tick();
    settle();
    chk("burst.len", {56'd0, rw_len_o}, 64'd3);
    tick();
    if_addr_valid_i = 0;
    beats = 0;
    for (int i = 0; i < 8; i++) begin
      r_data_valid_i = 1; r_data_i = 64'h100 + 64'(beats); if_r_ready_i = i[0];
      settle();
      chk("burst.r_valid",  {63'd0, if_r_valid_o}, 64'd1);
      chk("burst.r_ready",  {63'd0, r_data_ready_o}, {63'd0, if_r_ready_i});
      chk("burst.r_data",   if_r_data_o, 64'h100 + 64'(beats));
      if (if_r_ready_i) beats++;
      tick();
    end
    settle();
    chk("burst.after4_valid", {63'd0, if_r_valid_o}, 64'd0);
    chk("burst.after4_ready", {63'd0, r_data_ready_o}, 64'd0);
    r_data_valid_i = 0; if_r_ready_i = 0;

    // ---------------- reset mid LS read ----------------
    ls_addr_valid_i = 1; ls_addr_i = 32'h8000_0300; ls_we_i = 0; ls_len_i = 0;
    tick();
    tick();
    ls_addr_valid_i = 0; ls_r_ready_i = 1; r_data_valid_i = 1;
    rst = 1'b1;
    settle();
    chk_quiet("midrst");
    tick();
    rst = 1'b0; ls_r_ready_i = 0; r_data_valid_i = 0;
    if_addr_valid_i = 1; if_addr_i = 32'h8000_0400; if_len_i = 0;
    tick();
    settle();
    chk("midrst.if_addr",  {32'd0, rw_addr_o}, 64'h8000_0400);
    chk("midrst.if_valid", {63'd0, rw_addr_valid_o}, 64'd1);
    tick();
    if_addr_valid_i = 0; r_data_valid_i = 1; r_data_i = 64'hCAFE; if_r_ready_i = 1;
    settle();
    chk("midrst.if_r_valid", {63'd0, if_r_valid_o}, 64'd1);
    tick();
    r_data_valid_i = 0; if_r_ready_i = 0;

    // ---------------- address stall ----------------
    rw_addr_ready_i = 0;
    if_addr_valid_i = 1; if_addr_i = 32'h8000_0500; if_len_i = 0;
    tick();
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("stall.valid",    {63'd0, rw_addr_valid_o}, 64'd1);
      chk("stall.if_ready", {63'd0, if_addr_ready_o}, 64'd0);
      tick();
    end
    rw_addr_ready_i = 1;
    settle();
    chk("stall.release", {63'd0, if_addr_ready_o}, 64'd1);
    tick();
    if_addr_valid_i = 0; r_data_valid_i = 1; if_r_ready_i = 1;
    tick();
    r_data_valid_i = 0; if_r_ready_i = 0;
    settle();
    chk_quiet("stall.end");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ysyx_22050133_axi_arbiter.md
YSYX_22050133_AXI_ARBITER -- requirements
Module: ysyx_22050133_axi_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning request address width.
REQ-002 SHALL have parameter DATA_W, default 64, meaning data width.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port clk, input, 1, clock.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have IFU port if_addr_valid_i, input, 1; if_addr_ready_o, output, 1; if_addr_i, input, ADDR_W; if_len_i, input, 8; if_size_i, input, 3. IFU is read-only, INCR burst.
REQ-007 SHALL have IFU port if_r_valid_o, output, 1; if_r_ready_i, input, 1; if_r_data_o, output, DATA_W.
REQ-008 SHALL have LSU port ls_addr_valid_i, input, 1; ls_addr_ready_o, output, 1; ls_addr_i, input, ADDR_W; ls_we_i, input, 1; ls_len_i, input, 8; ls_size_i, input, 3.
REQ-009 SHALL have LSU port ls_w_valid_i, input, 1; ls_w_ready_o, output, 1; ls_w_data_i, input, DATA_W; ls_r_valid_o, output, 1; ls_r_ready_i, input, 1; ls_r_data_o, output, DATA_W; ls_w_done_o, output, 1 (one-cycle write-complete pulse).
REQ-010 SHALL have master port rw_addr_valid_o, output, 1; rw_addr_ready_i, input, 1; rw_addr_o, output, ADDR_W; rw_we_o, output, 1; rw_len_o, output, 8; rw_size_o, output, 3; rw_burst_o, output, 2.
REQ-011 SHALL have master port w_data_valid_o, output, 1; w_data_ready_i, input, 1; w_data_o, output, DATA_W; r_data_valid_i, input, 1; r_data_ready_o, output, 1; r_data_i, input, DATA_W.

Function
REQ-012 SHALL implement states IDLE, IF_RD, LS_RD, LS_WR, LS_WR_WAIT; one transaction outstanding at a time.
REQ-013 IDLE: pending request(s) sampled at posedge; grant entered next cycle; IDLE drives no master valid.
REQ-014 Arbitration SHALL be round-robin: single requester wins; on tie, winner is the client not granted last; last_grant register resets to LS, so IF wins the first tie.
REQ-015 Granted client's addr/we/len/size SHALL pass combinationally to rw_*; rw_burst_o = 2'b01; IF grant forces rw_we_o=0.
REQ-016 rw_addr_valid_o = granted client's valid AND not addr_sent; granted client's addr_ready_o = rw_addr_ready_i AND not addr_sent; ungranted addr_ready_o = 0.
REQ-017 addr_sent SHALL set on rw address handshake and clear on return to IDLE.
REQ-018 Beat counter (8 bits) SHALL load len at address handshake and decrement per data-beat handshake; last beat = counter 0.
REQ-019 IF_RD/LS_RD: granted r_valid_o = r_data_valid_i, r_data_o = r_data_i, r_data_ready_o = granted r_ready_i; other client r_valid_o = 0; last-beat handshake -> IDLE.
REQ-020 LS_WR: w_data_valid_o = ls_w_valid_i AND addr_sent, w_data_o = ls_w_data_i, ls_w_ready_o = w_data_ready_i AND addr_sent; last-beat handshake -> LS_WR_WAIT.
REQ-021 LS_WR_WAIT SHALL hold until rw_addr_ready_i = 1 (master B complete), then pulse ls_w_done_o for one cycle and -> IDLE.
REQ-022 Outside grant states all client ready/valid outputs SHALL be 0; r_data_ready_o = 0 outside *_RD.
REQ-023 Client request deasserted before handshake is a protocol violation; behaviour unspecified.
REQ-024 Back-to-back: next grant no earlier than one cycle after return to IDLE.

Reset
REQ-025 rst SHALL force IDLE, addr_sent=0, counter=0, last_grant=LS, all valid/ready/done outputs 0, immediately and independent of clk.
REQ-026 Reset mid-transaction SHALL abandon it without completing client handshakes; master reset together.

Structure
REQ-027 State encodings and BURST_INCR=2'b01 SHALL live in shared ysyx_22050133 defines/package beside AXI_SIZE constants.
REQ-028 Round-robin picker SHALL be sub-module ysyx_22050133_rr_pick2 (two requests, last_grant in, grant out); rest flat.

Verification
REQ-029 IF only, addr 0x8000_0000, len 0, r_data 0x1122334455667788 -> if_r_valid_o one beat, state back to IDLE, ls outputs 0.
REQ-030 IF and LS read same cycle after reset -> IF granted first, LS granted after IF last beat; then tie again -> LS.
REQ-031 LS write addr 0x8000_0010, len 1, data A,B -> two w beats forwarded, ls_w_done_o pulses once after rw_addr_ready_i returns 1.
REQ-032 IF burst len 3 with if_r_ready_i toggled 0/1 -> exactly 4 beats delivered, r_data_ready_o tracks if_r_ready_i.
REQ-033 rst asserted between address and data handshakes of LS read -> all outputs 0 same cycle, next IF request served normally.
REQ-034 rw_addr_ready_i held 0 for 5 cycles -> rw_addr_valid_o stable 1, client addr_ready_o 0 throughout.
